// File: rtl/serial_pattern_scan.sv
// serial_pattern_scan: byte-fed MSB-first serializer with overlapping pattern detector and per-frame match count
module serial_pattern_scan #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             match_pulse,
    output logic [CNT_W-1:0] match_count,
    output logic             done,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1011);
    localparam logic [2:0]       FULL    = 3'(PAT_W - 1);
    state_t             state_q;
    logic [PAT_W-1:0]   pat_q;
    logic [PAT_W-2:0]   win_q;
    logic [2:0]         fill_q;
    logic [7:0]         byte_q;
    logic               last_q;
    logic [2:0]         idx_q;
    logic               open_q;
    logic               pulse_q;
    logic               done_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [PAT_W-1:0]   cand_d;
    logic [PAT_W-2:0]   win_d;
    logic               hit_d;
    assign cand_d      = {win_q, byte_q[~idx_q]};
    assign win_d       = cand_d[PAT_W-2:0];
    assign hit_d       = (fill_q == FULL) && (cand_d == pat_q);
    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE) || open_q;
    assign match_pulse = pulse_q;
    assign match_count = cnt_q;
    assign done        = done_q;
    // Frame FSM: accept a byte, shift it out bit by bit through the detector, close frame on last
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= PAT_RST;
            win_q   <= '0;
            fill_q  <= '0;
            byte_q  <= '0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            open_q  <= 1'b0;
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
            if (cfg_we && !busy) pat_q <= cfg_pattern;
            case (state_q)
                IDLE: if (in_valid) begin
                    byte_q  <= in_data;
                    last_q  <= in_last;
                    idx_q   <= '0;
                    state_q <= SHIFT;
                    if (!open_q) begin
                        cnt_q  <= '0;
                        open_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    win_q <= win_d;
                    if (fill_q != FULL) fill_q <= fill_q + 3'd1;
                    if (hit_d) begin
                        pulse_q <= 1'b1;
                        cnt_q   <= cnt_q + CNT_W'(cnt_q != '1);
                    end
                    idx_q <= idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_q <= last_q ? DONE : IDLE;
                        done_q  <= last_q;
                    end
                end
                DONE: begin
                    win_q   <= '0;
                    fill_q  <= '0;
                    open_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
